spi_controller: RTL and testbench
=================================

// Module: spi_controller
// PURPOSE
//  SPI bus controller (initiator) for the byte-wide SPI peripheral in this design.
//  Generates sclk/ss/mosi from the system clock, shifts one byte out MSB-first and
//  captures one byte from miso per transfer. Can hold ss low across bytes so the
//  peripheral's response (returned one byte late) can be read in the next transfer.
//  Sits between the host-side command logic and the SPI pins.
// PARAMETERS
//  CLK_DIV   4   clk cycles per sclk half-period; legal range >= 2
// PORTS
//  clk       in   1  system clock; all logic on rising edge
//  rst       in   1  asynchronous reset, active-high
//  start     in   1  request a byte transfer; accepted only when busy==0
//  tx_data   in   8  byte to send; captured on the accept edge
//  keep_ss   in   1  captured on the accept edge; 1 = leave ss low after this byte
//  busy      out  1  high from the cycle after accept until ready for the next start
//  done      out  1  one-cycle pulse; rx_data is valid in that cycle
//  rx_data   out  8  last received byte; holds until the next done
//  sclk      out  1  SPI clock, idles low
//  ss        out  1  slave select, active-low
//  mosi      out  1  controller data out, MSB first
//  miso      in   1  peripheral data in
// BEHAVIOUR
//  - Reset (async, any state): sclk=0, ss=1, mosi=0, busy=0, done=0, rx_data=0x00,
//    state=IDLE, divider cleared. Mid-transfer reset aborts immediately: no done pulse.
//  - Timing: peripheral samples mosi and launches miso on rising sclk. The controller
//    changes mosi only while sclk is low. It samples miso on falling sclk.
//  - States: IDLE, SETUP, XFER, HOLD, GAP.
//    IDLE: ss=1, sclk=0, busy=0. start -> SETUP. Cycle after accept: ss=0,
//      mosi=tx_data[7], busy=1.
//    SETUP: wait CLK_DIV cycles with sclk=0, then -> XFER and drive the first rising sclk.
//    XFER: sclk toggles every CLK_DIV cycles for 16 half-periods (8 rising edges).
//      On each falling edge, shift miso into rx_shift[0]. On bits 0..6, also present
//      the next tx bit on mosi.
//      After the 8th falling edge: rx_data<=rx_shift, done=1 for one cycle, mosi=0.
//      Then -> HOLD if keep_ss, else -> GAP.
//    HOLD: ss=0, sclk=0, busy=0. start -> SETUP, with ss staying low and
//      mosi=tx_data[7]. A start in the same cycle as done is accepted.
//      To release ss, start with keep_ss=0, or assert rst.
//    GAP: ss=1, busy=1 for CLK_DIV cycles (min ss-high time), then -> IDLE.
//  - Latency: done is high exactly 1+17*CLK_DIV cycles after the accept edge.
//  - start while busy=1 is ignored (no queueing). tx_data and keep_ss are don't-care
//    outside the accept edge.
//  - The divider runs only in SETUP, XFER and GAP. It restarts at 0 on every state entry.
//  - sclk, ss and mosi come straight from flops (glitch-free).
// STRUCTURE
//  - spi_pkg: state enum (IDLE, SETUP, XFER, HOLD, GAP), SPI_BYTE_W=8,
//    SPI_TEST_CMD=8'h8F, SPI_TEST_RESP=8'hAA. Shared with the peripheral benches.
//  - Sub-module spi_clk_div: half-period tick generator (CLK_DIV, clear, enable -> tick).
//  - Top level holds the FSM, tx/rx shift registers, half-period counter (0..15) and
//    keep_ss flag.
// TESTING (CLK_DIV=2 unless noted; bench models the peripheral: mode-0 sampling,
//  response one byte late)
//  1. Reset: rst pulse mid-bench -> ss=1, sclk=0, mosi=0, busy=0, done=0, rx_data=0x00
//     with no clk edge.
//  2. Single byte: start with tx_data=0x8F, keep_ss=0 -> 8 sclk pulses; model receives
//     0x8F; done at 35 cycles; ss high in GAP; busy low 2 cycles later.
//  3. Back-to-back: 0x8F with keep_ss=1, then 0x00 with keep_ss=0 issued in the done
//     cycle -> ss never rises between bytes; second rx_data=0xAA.
//  4. Config read: 0x90 then 0x00 with the model config_data=0xDEADBEEF ->
//     second rx_data=0xBE. Command 0x10 -> 0x00.
//  5. Start during busy: extra start pulses at cycles 3 and 20 -> ignored; exactly one
//     done; mosi sequence unchanged.
//  6. CLK_DIV=5, reset at 3rd rising sclk -> immediate ss=1/sclk=0; no done; a new
//     transfer of 0x3C completes correctly.

Source files
------------

// File: rtl/spi_pkg.sv
// Shared SPI definitions: controller state encoding, byte width and the test
// command/response pair used by the peripheral and its benches.
package spi_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        XFER,
        HOLD,
        GAP
    } spi_state_t;

    localparam int         SPI_BYTE_W    = 8;
    localparam logic [7:0] SPI_TEST_CMD  = 8'h8F;
    localparam logic [7:0] SPI_TEST_RESP = 8'hAA;

endpackage

// File: rtl/spi_clk_div.sv
// Half-period tick generator: pulses tick for one clk every CLK_DIV enabled cycles,
// restarting from zero whenever clear is asserted.
module spi_clk_div #(
    parameter int CLK_DIV = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic tick
);
    localparam int               CNT_W   = $clog2(CLK_DIV);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CLK_DIV - 1);

    logic [CNT_W-1:0] cnt;

    // tick ignores clear so the FSM can use it to decide a transition without a loop
    assign tick = enable && (cnt == CNT_MAX);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (clear || tick) begin
            cnt <= '0;
        end else if (enable) begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/spi_controller.sv
// SPI initiator: shifts one byte out MSB-first on mosi and captures one byte from miso
// per transfer; optionally keeps ss low so the following byte continues the frame.
module spi_controller
    import spi_pkg::*;
#(
    parameter int CLK_DIV = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [SPI_BYTE_W-1:0] tx_data,
    input  logic                  keep_ss,
    output logic                  busy,
    output logic                  done,
    output logic [SPI_BYTE_W-1:0] rx_data,
    output logic                  sclk,
    output logic                  ss,
    output logic                  mosi,
    input  logic                  miso
);
    localparam logic [3:0] LAST_HALF = 4'd15;
    localparam logic [3:0] LAST_FALL = 4'd14;

    spi_state_t            state_q;
    spi_state_t            state_d;
    logic [3:0]            half_cnt;
    logic [SPI_BYTE_W-1:0] tx_shift;
    logic [SPI_BYTE_W-1:0] rx_shift;
    logic                  keep_q;
    logic                  tick;
    logic                  div_clr;

    assign busy    = (state_q == SETUP) || (state_q == XFER) || (state_q == GAP);
    assign div_clr = (state_d != state_q);

    spi_clk_div #(
        .CLK_DIV (CLK_DIV)
    ) u_clk_div (
        .clk    (clk),
        .rst    (rst),
        .clear  (div_clr),
        .enable (busy),
        .tick   (tick)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // NOTE: state_d gets its default before the case so no path leaves it unassigned (no latch).
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE, HOLD: if (start) state_d = SETUP;
            SETUP:      if (tick) state_d = XFER;
            XFER:       if (tick && (half_cnt == LAST_HALF)) state_d = keep_q ? HOLD : GAP;
            GAP:        if (tick) state_d = IDLE;
            default:    state_d = IDLE;
        endcase
    end

    // NOTE: flops use non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sclk     <= 1'b0;
            ss       <= 1'b1;
            mosi     <= 1'b0;
            done     <= 1'b0;
            rx_data  <= '0;
            tx_shift <= '0;
            rx_shift <= '0;
            keep_q   <= 1'b0;
            half_cnt <= '0;
        end else begin
            done <= 1'b0;
            case (state_q)
                IDLE, HOLD: begin
                    if (start) begin
                        tx_shift <= tx_data;
                        keep_q   <= keep_ss;
                        ss       <= 1'b0;
                        mosi     <= tx_data[SPI_BYTE_W-1];
                        half_cnt <= '0;
                    end
                end
                SETUP: begin
                    if (tick) sclk <= 1'b1;
                end
                XFER: begin
                    if (tick) begin
                        half_cnt <= half_cnt + 4'd1;
                        if (half_cnt == LAST_HALF) begin
                            // final low half-period has elapsed: publish the byte
                            rx_data <= rx_shift;
                            done    <= 1'b1;
                            mosi    <= 1'b0;
                            ss      <= ~keep_q;
                        end else begin
                            sclk <= ~sclk;
                            if (sclk) begin
                                rx_shift <= {rx_shift[SPI_BYTE_W-2:0], miso};
                                if (half_cnt != LAST_FALL) begin
                                    mosi     <= tx_shift[SPI_BYTE_W-2];
                                    tx_shift <= {tx_shift[SPI_BYTE_W-2:0], 1'b0};
                                end
                            end
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_spi_controller.sv
// Bench for spi_controller: lane 0 runs CLK_DIV=2, lane 1 runs CLK_DIV=5, each with a
// pin-level peripheral model that answers one byte late within an ss-low frame.
module tb_spi_controller;
    localparam int         N_LANE     = 2;
    localparam int         MAX_WAIT   = 3000;
    localparam logic [12:0] RESET_PINS = {1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00};

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start_v   [N_LANE];
    logic [7:0]  tx_v      [N_LANE];
    logic        keep_v    [N_LANE];
    logic        busy_v    [N_LANE];
    logic        done_v    [N_LANE];
    logic [7:0]  rx_data_v [N_LANE];
    logic        sclk_v    [N_LANE];
    logic        ss_v      [N_LANE];
    logic        mosi_v    [N_LANE];
    logic [7:0]  rx_last_v [N_LANE];
    int          rx_cnt_v    [N_LANE];
    int          done_cnt_v  [N_LANE];
    int          sclk_rise_v [N_LANE];
    int          ss_rise_v   [N_LANE];
    logic [31:0] config_data = 32'h0;
    int          n_cmp = 0;
    int          n_bad = 0;

    always #5 clk = ~clk;

    // Peripheral rule: test command answers the fixed pattern, other reads (bit 7) return
    // config byte cmd[5:4], anything else answers zero.
    function automatic logic [7:0] resp_of(input logic [7:0] cmd);
        if (cmd == spi_pkg::SPI_TEST_CMD) return spi_pkg::SPI_TEST_RESP;
        if (cmd[7]) return config_data[{cmd[5:4], 3'b000} +: 8];
        return 8'h00;
    endfunction

    function automatic int div_of(input int ln);
        return (ln == 0) ? 2 : 5;
    endfunction

    function automatic logic [12:0] pins(input int ln);
        return {ss_v[ln], sclk_v[ln], mosi_v[ln], busy_v[ln], done_v[ln], rx_data_v[ln]};
    endfunction

    for (genvar g = 0; g < N_LANE; g++) begin : g_lane
        logic       busy, done, sclk, ss, mosi;
        logic [7:0] rx_data;
        logic       miso     = 1'b0;
        logic [2:0] bit_idx  = 3'd0;
        logic [7:0] shift_in = 8'h00;
        logic [7:0] resp     = 8'h00;
        logic [7:0] last     = 8'h00;
        int         n_rx = 0, n_done = 0, n_sclk = 0, n_ss = 0;

        spi_controller #(
            .CLK_DIV (g == 0 ? 2 : 5)
        ) u_dut (
            .clk     (clk),
            .rst     (rst),
            .start   (start_v[g]),
            .tx_data (tx_v[g]),
            .keep_ss (keep_v[g]),
            .busy    (busy),
            .done    (done),
            .rx_data (rx_data),
            .sclk    (sclk),
            .ss      (ss),
            .mosi    (mosi),
            .miso    (miso)
        );

        always @(posedge sclk or posedge ss) begin
            if (ss) begin
                bit_idx  <= 3'd0;
                shift_in <= 8'h00;
                resp     <= 8'h00;
                miso     <= 1'b0;
            end else begin
                miso     <= resp[3'd7 - bit_idx];
                shift_in <= {shift_in[6:0], mosi};
                bit_idx  <= bit_idx + 3'd1;
                if (bit_idx == 3'd7) begin
                    last <= {shift_in[6:0], mosi};
                    n_rx <= n_rx + 1;
                    resp <= resp_of({shift_in[6:0], mosi});
                end
            end
        end

        always @(posedge clk) if (done === 1'b1) n_done <= n_done + 1;
        always @(posedge sclk) n_sclk <= n_sclk + 1;
        always @(posedge ss) n_ss <= n_ss + 1;

        assign busy_v[g]      = busy;
        assign done_v[g]      = done;
        assign rx_data_v[g]   = rx_data;
        assign sclk_v[g]      = sclk;
        assign ss_v[g]        = ss;
        assign mosi_v[g]      = mosi;
        assign rx_last_v[g]   = last;
        assign rx_cnt_v[g]    = n_rx;
        assign done_cnt_v[g]  = n_done;
        assign sclk_rise_v[g] = n_sclk;
        assign ss_rise_v[g]   = n_ss;
    end

    // Called just after a negedge with the lane ready; returns at the negedge of the done cycle.
    task automatic run_byte(input int ln, input logic [7:0] tx, input logic keep,
                            output int lat, output logic [7:0] rx);
        start_v[ln] = 1'b1;
        tx_v[ln]    = tx;
        keep_v[ln]  = keep;
        @(posedge clk);
        @(negedge clk);
        start_v[ln] = 1'b0;
        tx_v[ln]    = 8'($urandom);
        keep_v[ln]  = 1'($urandom);
        lat = 1;
        while (done_v[ln] !== 1'b1 && lat < MAX_WAIT) begin
            @(negedge clk);
            lat++;
        end
        rx = rx_data_v[ln];
    endtask

    task automatic wait_idle(input int ln);
        int k = 0;
        while (busy_v[ln] !== 1'b0 && k < MAX_WAIT) begin
            @(negedge clk);
            k++;
        end
        n_cmp++;
        if (busy_v[ln] !== 1'b0) begin
            n_bad++;
            $display("FAIL idle_wait lane%0d: busy=%b after %0d cycles, required 0", ln, busy_v[ln], k);
        end
    endtask

    task automatic test_reset();
        #1 rst = 1'b1;
        repeat (3) @(negedge clk);
        for (int ln = 0; ln < N_LANE; ln++) begin
            n_cmp++;
            if (pins(ln) !== RESET_PINS) begin
                n_bad++;
                $display("FAIL reset_pins lane%0d: got %h required %h", ln, pins(ln), RESET_PINS);
            end
        end
        rst = 1'b0;
        repeat (2) @(negedge clk);
        n_cmp++;
        if (pins(0) !== RESET_PINS) begin
            n_bad++;
            $display("FAIL reset_release: got %h required %h", pins(0), RESET_PINS);
        end
    endtask

    task automatic test_single();
        int lat, rx_base, sclk_base;
        logic [7:0] rx;
        rx_base   = rx_cnt_v[0];
        sclk_base = sclk_rise_v[0];
        run_byte(0, 8'h8F, 1'b0, lat, rx);
        n_cmp++;
        if (lat !== 1 + 17 * div_of(0)) begin
            n_bad++;
            $display("FAIL single_latency: got %0d required %0d", lat, 1 + 17 * div_of(0));
        end
        n_cmp++;
        if (sclk_rise_v[0] - sclk_base !== 8) begin
            n_bad++;
            $display("FAIL single_sclk_pulses: got %0d required 8", sclk_rise_v[0] - sclk_base);
        end
        n_cmp++;
        if (rx_last_v[0] !== 8'h8F || rx_cnt_v[0] - rx_base !== 1) begin
            n_bad++;
            $display("FAIL single_model_rx: got %h (%0d bytes) required 8f (1 byte)",
                     rx_last_v[0], rx_cnt_v[0] - rx_base);
        end
        n_cmp++;
        if (rx !== 8'h00) begin
            n_bad++;
            $display("FAIL single_rx_data: got %h required 00", rx);
        end
        n_cmp++;
        if ({ss_v[0], busy_v[0]} !== 2'b11) begin
            n_bad++;
            $display("FAIL single_gap: ss/busy got %b%b required 11", ss_v[0], busy_v[0]);
        end
        @(negedge clk);
        n_cmp++;
        if (busy_v[0] !== 1'b1) begin
            n_bad++;
            $display("FAIL single_gap_busy: got %b required 1", busy_v[0]);
        end
        @(negedge clk);
        n_cmp++;
        if (busy_v[0] !== 1'b0 || ss_v[0] !== 1'b1) begin
            n_bad++;
            $display("FAIL single_idle: busy/ss got %b%b required 01", busy_v[0], ss_v[0]);
        end
    endtask

    task automatic test_back_to_back();
        int lat, ss_base;
        logic [7:0] rx;
        ss_base = ss_rise_v[0];
        run_byte(0, 8'h8F, 1'b1, lat, rx);
        n_cmp++;
        if ({ss_v[0], busy_v[0]} !== 2'b00) begin
            n_bad++;
            $display("FAIL b2b_hold: ss/busy got %b%b required 00", ss_v[0], busy_v[0]);
        end
        run_byte(0, 8'h00, 1'b0, lat, rx);
        n_cmp++;
        if (rx !== spi_pkg::SPI_TEST_RESP) begin
            n_bad++;
            $display("FAIL b2b_rx_data: got %h required %h", rx, spi_pkg::SPI_TEST_RESP);
        end
        n_cmp++;
        if (lat !== 1 + 17 * div_of(0)) begin
            n_bad++;
            $display("FAIL b2b_latency: got %0d required %0d", lat, 1 + 17 * div_of(0));
        end
        n_cmp++;
        if (ss_rise_v[0] - ss_base !== 1) begin
            n_bad++;
            $display("FAIL b2b_ss_rises: got %0d required 1", ss_rise_v[0] - ss_base);
        end
        wait_idle(0);
    endtask

    task automatic test_config_read();
        logic [7:0] cmds [3] = '{8'h90, 8'h10, 8'hB0};
        logic [7:0] exps [3] = '{8'hBE, 8'h00, 8'hDE};
        int lat;
        logic [7:0] rx;
        config_data = 32'hDEADBEEF;
        for (int i = 0; i < 3; i++) begin
            run_byte(0, cmds[i], 1'b1, lat, rx);
            run_byte(0, 8'h00, 1'b0, lat, rx);
            n_cmp++;
            if (rx !== exps[i]) begin
                n_bad++;
                $display("FAIL cfg_read cmd %h: got %h required %h", cmds[i], rx, exps[i]);
            end
            wait_idle(0);
        end
    endtask

    task automatic test_start_during_busy();
        int k, done_base, rx_base;
        done_base = done_cnt_v[0];
        rx_base   = rx_cnt_v[0];
        start_v[0] = 1'b1;
        tx_v[0]    = 8'hC3;
        keep_v[0]  = 1'b0;
        @(posedge clk);
        @(negedge clk);
        start_v[0] = 1'b0;
        k = 1;
        while (done_v[0] !== 1'b1 && k < MAX_WAIT) begin
            @(negedge clk);
            k++;
            start_v[0] = (k == 3 || k == 20);
            tx_v[0]    = 8'hFF;
            keep_v[0]  = 1'b1;
        end
        start_v[0] = 1'b0;
        n_cmp++;
        if (k !== 1 + 17 * div_of(0)) begin
            n_bad++;
            $display("FAIL busy_latency: got %0d required %0d", k, 1 + 17 * div_of(0));
        end
        repeat (60) @(negedge clk);
        n_cmp++;
        if (rx_last_v[0] !== 8'hC3 || rx_cnt_v[0] - rx_base !== 1) begin
            n_bad++;
            $display("FAIL busy_mosi_seq: got %h (%0d bytes) required c3 (1 byte)",
                     rx_last_v[0], rx_cnt_v[0] - rx_base);
        end
        n_cmp++;
        if (done_cnt_v[0] - done_base !== 1) begin
            n_bad++;
            $display("FAIL busy_done_count: got %0d required 1", done_cnt_v[0] - done_base);
        end
        n_cmp++;
        if ({ss_v[0], busy_v[0]} !== 2'b10) begin
            n_bad++;
            $display("FAIL busy_end_state: ss/busy got %b%b required 10", ss_v[0], busy_v[0]);
        end
    endtask

    task automatic test_async_reset();
        int lat, done_base;
        logic [7:0] rx;
        run_byte(0, 8'h8F, 1'b1, lat, rx);
        run_byte(0, 8'h00, 1'b1, lat, rx);
        start_v[0] = 1'b1;
        tx_v[0]    = 8'h8F;
        keep_v[0]  = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start_v[0] = 1'b0;
        repeat (9) @(negedge clk);
        done_base = done_cnt_v[0];
        n_cmp++;
        if ({ss_v[0], rx_data_v[0]} !== {1'b0, spi_pkg::SPI_TEST_RESP}) begin
            n_bad++;
            $display("FAIL arst_precondition: ss/rx got %b/%h required 0/aa", ss_v[0], rx_data_v[0]);
        end
        #1 rst = 1'b1;
        #1;
        n_cmp++;
        if (pins(0) !== RESET_PINS) begin
            n_bad++;
            $display("FAIL arst_pins: got %h required %h", pins(0), RESET_PINS);
        end
        @(negedge clk);
        rst = 1'b0;
        repeat (80) @(negedge clk);
        n_cmp++;
        if (done_cnt_v[0] !== done_base) begin
            n_bad++;
            $display("FAIL arst_no_done: got %0d extra done required 0", done_cnt_v[0] - done_base);
        end
        run_byte(0, 8'h8F, 1'b0, lat, rx);
        n_cmp++;
        if (rx_last_v[0] !== 8'h8F || rx !== 8'h00) begin
            n_bad++;
            $display("FAIL arst_recover: model %h rx %h required 8f/00", rx_last_v[0], rx);
        end
        wait_idle(0);
    endtask

    task automatic test_random();
        logic [7:0] tx, prev_tx, rx, exp_rx;
        logic       keep, prev_keep;
        int         lat;
        config_data = $urandom;
        prev_keep   = 1'b0;
        prev_tx     = 8'h00;
        for (int i = 0; i < 24; i++) begin
            tx     = 8'($urandom);
            keep   = (i == 23) ? 1'b0 : 1'($urandom_range(0, 1));
            exp_rx = prev_keep ? resp_of(prev_tx) : 8'h00;
            run_byte(0, tx, keep, lat, rx);
            n_cmp++;
            if (lat !== 1 + 17 * div_of(0) || rx !== exp_rx || rx_last_v[0] !== tx) begin
                n_bad++;
                $display("FAIL rand_byte %0d tx %h: lat %0d rx %h model %h required lat %0d rx %h",
                         i, tx, lat, rx, rx_last_v[0], 1 + 17 * div_of(0), exp_rx);
            end
            if (keep) repeat ($urandom_range(0, 3)) @(negedge clk);
            else wait_idle(0);
            prev_keep = keep;
            prev_tx   = tx;
        end
    endtask

    task automatic test_clkdiv5_reset();
        int k, lat, sclk_base, done_base;
        logic [7:0] rx;
        sclk_base = sclk_rise_v[1];
        done_base = done_cnt_v[1];
        start_v[1] = 1'b1;
        tx_v[1]    = 8'h5A;
        keep_v[1]  = 1'b0;
        @(posedge clk);
        @(negedge clk);
        start_v[1] = 1'b0;
        k = 0;
        while (sclk_rise_v[1] - sclk_base < 3 && k < MAX_WAIT) begin
            @(negedge clk);
            k++;
        end
        n_cmp++;
        if (sclk_rise_v[1] - sclk_base !== 3 || sclk_v[1] !== 1'b1) begin
            n_bad++;
            $display("FAIL div5_third_rise: rises %0d sclk %b required 3/1",
                     sclk_rise_v[1] - sclk_base, sclk_v[1]);
        end
        #1 rst = 1'b1;
        #1;
        n_cmp++;
        if (pins(1) !== RESET_PINS) begin
            n_bad++;
            $display("FAIL div5_reset_pins: got %h required %h", pins(1), RESET_PINS);
        end
        @(negedge clk);
        rst = 1'b0;
        repeat (150) @(negedge clk);
        n_cmp++;
        if (done_cnt_v[1] !== done_base) begin
            n_bad++;
            $display("FAIL div5_no_done: got %0d extra done required 0", done_cnt_v[1] - done_base);
        end
        run_byte(1, 8'h3C, 1'b0, lat, rx);
        n_cmp++;
        if (lat !== 1 + 17 * div_of(1) || rx_last_v[1] !== 8'h3C || rx !== 8'h00) begin
            n_bad++;
            $display("FAIL div5_xfer: lat %0d model %h rx %h required %0d/3c/00",
                     lat, rx_last_v[1], rx, 1 + 17 * div_of(1));
        end
        wait_idle(1);
    endtask

    initial begin
        for (int ln = 0; ln < N_LANE; ln++) begin
            start_v[ln] = 1'b0;
            tx_v[ln]    = 8'h00;
            keep_v[ln]  = 1'b0;
        end
        test_reset();
        test_single();
        test_back_to_back();
        test_config_read();
        test_start_during_busy();
        test_async_reset();
        test_random();
        test_clkdiv5_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
